// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute operand fetch with RAW scoreboard and same-edge writeback bypass
//   clk, reset_n (sync, active-high) | in_*: decoded instruction, in_ready handshake
//   rf_read_addr1/2 -> register file, rf_read_data1/2 <- one cycle later
//   wb_*: writeback strobe/index/data | out_*: operands + passthrough to execute
//   busy_mask: pending-write scoreboard
//   OPFETCH_ZERO_REG_EN: register 0 hardwired to zero
module operand_fetch #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_wen,
    input  logic [TAG_W-1:0] in_tag,
    output logic [4:0]       rf_read_addr1,
    output logic [4:0]       rf_read_addr2,
    input  logic [XLEN-1:0]  rf_read_data1,
    input  logic [XLEN-1:0]  rf_read_data2,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      busy_mask
);
    typedef enum logic [1:0] {IDLE, READ, VALID} state_t;
    state_t            r_state;
    logic [31:0]       r_busy;
    logic              r_byp1, r_byp2;
    logic [XLEN-1:0]   r_bd1, r_bd2;
    logic              w_hit1, w_hit2, w_z1, w_z2, w_acc;
    logic [31:0]       w_set, w_clr, w_busy_next;
`ifdef OPFETCH_ZERO_REG_EN
    localparam logic [31:0] BUSY_KEEP = 32'hFFFF_FFFE;
    assign w_z1 = in_rs1 == 5'd0;
    assign w_z2 = in_rs2 == 5'd0;
`else
    localparam logic [31:0] BUSY_KEEP = 32'hFFFF_FFFF;
    assign w_z1 = 1'b0;
    assign w_z2 = 1'b0;
`endif
    assign rf_read_addr1 = in_rs1;
    assign rf_read_addr2 = in_rs2;
    assign busy_mask     = r_busy;
    // A writeback landing on this edge resolves the hazard; its data is bypassed
    assign w_hit1   = wb_valid && wb_addr == in_rs1;
    assign w_hit2   = wb_valid && wb_addr == in_rs2;
    assign in_ready = r_state == IDLE && !(r_busy[in_rs1] && !w_hit1) && !(r_busy[in_rs2] && !w_hit2);
    assign w_acc    = in_valid && in_ready;
    // Set is applied after clear so a same-edge set/clear of one bit leaves it set
    assign w_set       = (w_acc && in_wen) ? 32'd1 << in_rd : 32'd0;
    assign w_clr       = wb_valid ? 32'd1 << wb_addr : 32'd0;
    assign w_busy_next = ((r_busy & ~w_clr) | w_set) & BUSY_KEEP;
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state   <= IDLE;
            r_busy    <= '0;
            r_byp1    <= 1'b0;
            r_byp2    <= 1'b0;
            r_bd1     <= '0;
            r_bd2     <= '0;
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
            out_tag   <= '0;
        end else begin
            r_busy <= w_busy_next;
            case (r_state)
                IDLE: if (w_acc) begin
                    r_state <= READ;
                    out_rd  <= in_rd;
                    out_wen <= in_wen;
                    out_tag <= in_tag;
                    // Hardwired zero reuses the bypass path with a zero payload
                    r_byp1  <= w_hit1 || w_z1;
                    r_byp2  <= w_hit2 || w_z2;
                    r_bd1   <= w_z1 ? '0 : wb_data;
                    r_bd2   <= w_z2 ? '0 : wb_data;
                end
                READ: begin
                    r_state   <= VALID;
                    out_valid <= 1'b1;
                    out_op1   <= r_byp1 ? r_bd1 : rf_read_data1;
                    out_op2   <= r_byp2 ? r_bd2 : rf_read_data2;
                end
                VALID: if (out_ready) begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vector and corner-case bench for operand_fetch
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, in_wen, wb_valid, out_valid, out_ready, out_wen;
    logic [4:0]  in_rs1, in_rs2, in_rd, rf_read_addr1, rf_read_addr2, wb_addr, out_rd;
    logic [31:0] in_tag, out_tag, busy_mask;
    logic [63:0] rf_read_data1, rf_read_data2, wb_data, out_op1, out_op2;
    int checks = 0;
    int errors = 0;
`ifdef OPFETCH_ZERO_REG_EN
    localparam logic [63:0] R0 = 64'h0;
    localparam logic [31:0] B0 = 32'h0;
`else
    localparam logic [63:0] R0 = 64'hDEAD;
    localparam logic [31:0] B0 = 32'h1;
`endif
    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen), .in_tag(in_tag),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_wen(out_wen), .out_tag(out_tag), .busy_mask(busy_mask)
    );

    // Register file model: registered read returning the pre-write value on a same-edge write
    logic [63:0] regs [32];
    logic [31:0] written = '0;
    function automatic logic [63:0] init_val(input logic [4:0] a);
        return a == 5'd0 ? 64'hDEAD : a == 5'd4 ? 64'd1 : a == 5'd5 ? 64'd12 : a == 5'd10 ? 64'd14 : 64'h1000 + 64'(a);
    endfunction
    always @(posedge clk) begin
        rf_read_data1 <= written[rf_read_addr1] ? regs[rf_read_addr1] : init_val(rf_read_addr1);
        rf_read_data2 <= written[rf_read_addr2] ? regs[rf_read_addr2] : init_val(rf_read_addr2);
        if (wb_valid) begin
            regs[wb_addr]    <= wb_data;
            written[wb_addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic wen);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_wen   = wen;
    endtask

    task automatic quiet();
        in_valid = 1'b0;
        wb_valid = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        wbv;
        logic [4:0]  wba;
        logic [63:0] wbd, e1, e2;
    } vec_t;
    vec_t vt [5];

    initial begin
        vt[0] = '{5'd5, 5'd10, 5'd20, 1'b0, 5'd0, 64'h0, 64'd12, 64'd14};
        vt[1] = '{5'd1, 5'd4, 5'd21, 1'b1, 5'd4, 64'h1234567890ABCDEF, 64'h1001, 64'h1234567890ABCDEF};
        vt[2] = '{5'd4, 5'd4, 5'd22, 1'b0, 5'd0, 64'h0, 64'h1234567890ABCDEF, 64'h1234567890ABCDEF};
        vt[3] = '{5'd0, 5'd6, 5'd23, 1'b0, 5'd0, 64'h0, R0, 64'h1006};
        vt[4] = '{5'd3, 5'd3, 5'd24, 1'b1, 5'd3, 64'h55, 64'h55, 64'h55};
        reset_n = 1'b1; out_ready = 1'b0; in_tag = '0; wb_addr = '0; wb_data = '0;
        quiet();
        present(5'd1, 5'd1, 5'd0, 1'b0);
        in_valid = 1'b0;
        step(); step();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy_mask), 64'd0);
        chk("reset op1", out_op1, 64'd0);
        chk("reset tag", 64'(out_tag), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            present(vt[i].rs1, vt[i].rs2, vt[i].rd, 1'b0);
            in_tag   = 32'hC0DE_0000 + 32'(i);
            wb_valid = vt[i].wbv;
            wb_addr  = vt[i].wba;
            wb_data  = vt[i].wbd;
            #1;
            chk($sformatf("v%0d ready", i), 64'(in_ready), 64'd1);
            step();
            quiet();
            chk($sformatf("v%0d read phase", i), 64'(out_valid), 64'd0);
            step();
            chk($sformatf("v%0d valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d op1", i), out_op1, vt[i].e1);
            chk($sformatf("v%0d op2", i), out_op2, vt[i].e2);
            chk($sformatf("v%0d rd", i), 64'(out_rd), 64'(vt[i].rd));
            chk($sformatf("v%0d tag", i), 64'(out_tag), 64'(32'hC0DE_0000 + 32'(i)));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("v%0d drained", i), 64'(out_valid), 64'd0);
        end

        // RAW stall resolved by a writeback on the accept edge
        present(5'd1, 5'd1, 5'd2, 1'b1);
        step();
        quiet();
        chk("raw busy set", 64'(busy_mask), 64'h4);
        step();
        chk("raw producer wen", 64'(out_wen), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        present(5'd2, 5'd1, 5'd8, 1'b0);
        #1;
        chk("raw stalled", 64'(in_ready), 64'd0);
        step(); step();
        chk("raw still stalled", 64'(in_ready), 64'd0);
        chk("raw no issue", 64'(out_valid), 64'd0);
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 64'hAA55AA55AA55AA55;
        #1;
        chk("raw ready on wb", 64'(in_ready), 64'd1);
        step();
        quiet();
        chk("raw busy cleared", 64'(busy_mask), 64'd0);
        step();
        chk("raw valid", 64'(out_valid), 64'd1);
        chk("raw op1", out_op1, 64'hAA55AA55AA55AA55);
        chk("raw op2", out_op2, 64'h1001);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Set/clear collision on register 9
        present(5'd1, 5'd1, 5'd9, 1'b1);
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 64'h99;
        step();
        quiet();
        chk("collision set wins", 64'(busy_mask), 64'h200);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd9;
        step();
        wb_valid = 1'b0;
        chk("collision later clear", 64'(busy_mask), 64'd0);

        // Backpressure: outputs frozen while VALID and not ready
        present(5'd5, 5'd10, 5'd13, 1'b0);
        in_tag = 32'hB0B0_0001;
        step();
        quiet();
        step();
        present(5'd6, 5'd7, 5'd14, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d op1", c), out_op1, 64'd12);
            chk($sformatf("bp%0d op2", c), out_op2, 64'd14);
            chk($sformatf("bp%0d rd", c), 64'(out_rd), 64'd13);
            chk($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp drained", 64'(out_valid), 64'd0);

        // Register 0 as destination and source
        present(5'd0, 5'd0, 5'd0, 1'b1);
        step();
        quiet();
        chk("r0 busy", 64'(busy_mask), 64'(B0));
        step();
        chk("r0 op1", out_op1, R0);
        chk("r0 op2", out_op2, R0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 64'h77;
        step();
        wb_valid = 1'b0;
        chk("r0 cleared", 64'(busy_mask), 64'd0);

        // Reset while VALID
        present(5'd3, 5'd1, 5'd7, 1'b1);
        step();
        quiet();
        step();
        chk("rst pre valid", 64'(out_valid), 64'd1);
        chk("rst pre busy", 64'(busy_mask), 64'h80);
        reset_n = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd12;
        step();
        reset_n = 1'b0;
        wb_valid = 1'b0;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst busy", 64'(busy_mask), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst op1", out_op1, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage between instruction decode and execute. Accepts one decoded instruction at a time, drives the register file's read addresses, and collects the 64-bit operands one cycle later. It tracks in-flight destination registers in a 32-entry scoreboard and stalls on read-after-write hazards. It also bypasses same-cycle writeback data, because the register file returns the old value when a read and a write to the same register land on the same edge.

## Interface
- XLEN, 64, operand/data width
- TAG_W, 32, opaque instruction tag (PC/opcode) carried alongside operands
- clk  input  1  sole clock, all state on posedge
- reset_n  input  1  synchronous, active-high reset (1 = reset)
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts instruction this cycle
- in_rs1, in_rs2  input  5  source register indices
- in_rd  input  5  destination register index
- in_wen  input  1  instruction writes in_rd
- in_tag  input  TAG_W  passthrough tag
- rf_read_addr1, rf_read_addr2  output  5  register file read addresses; combinational copies of in_rs1/in_rs2
- rf_read_data1, rf_read_data2  input  XLEN  register file read data, registered one cycle after the address
- wb_valid  input  1  writeback committing this cycle (same strobe as the register file write_enable)
- wb_addr  input  5  writeback register index
- wb_data  input  XLEN  writeback value
- out_valid  output  1  operands valid to execute
- out_ready  input  1  execute accepts
- out_op1, out_op2  output  XLEN  resolved operands
- out_rd, out_wen, out_tag  output  5/1/TAG_W  registered passthrough
- busy_mask  output  32  scoreboard, bit i = register i has a pending write

## Operation
- The FSM has three states: IDLE, READ and VALID. Reset enters IDLE.
- Hazard for a source rsN: busy_mask[rsN] set and not (wb_valid and wb_addr==rsN). hazard = hazard(rs1) or hazard(rs2).
- in_ready = (state==IDLE) and not hazard.
- IDLE to READ on in_valid and in_ready (the accept edge):
  - Capture in_rd, in_wen and in_tag.
  - For each source, record bypass flag = (wb_valid and wb_addr==rsN) and capture wb_data into a bypass register.
  - If in_wen, set busy_mask[in_rd].
- READ to VALID, unconditionally after one cycle:
  - out_opN = bypass flag ? bypass register : rf_read_dataN.
  - Assert out_valid.
- VALID to IDLE on out_ready. Operands and passthrough fields are held stable while out_valid=1 and out_ready=0.
- Scoreboard clear: on any cycle with wb_valid, clear busy_mask[wb_addr]. A writeback to a non-pending register has no effect on the scoreboard.
- Simultaneous set and clear of the same bit (accept with in_wen and in_rd==wb_addr): set wins.
- Only one instruction is in flight inside the stage. in_valid while not ready is ignored, and upstream holds its fields.

## Timing
- Reset values: out_valid=0, out_op1=out_op2=0, out_rd=0, out_wen=0, out_tag=0, busy_mask=0, state=IDLE.
- in_ready is combinational and may be 1 during reset-release cycle only if state is IDLE.
- Latency: accept at edge E0, out_valid=1 after edge E1 (operands appear 2 cycles after in_valid/in_ready).
- Maximum throughput is one instruction per 3 cycles (IDLE, READ, VALID with out_ready=1).
- Reset asserted in any state: on the next edge, discard the in-flight instruction, clear the scoreboard, and go to IDLE. wb_valid is ignored during reset.
- A stalled instruction is accepted on the first edge where the blocking register's writeback is visible on wb_*. The bypass supplies that value.

## Configuration
- OPFETCH_ZERO_REG_EN
  - Defined: register 0 is hardwired zero. Reads of index 0 return 0 regardless of rf or bypass. An accept with in_rd==0 never sets busy_mask[0], and busy_mask[0] is constantly 0.
  - Undefined: register 0 is an ordinary register with full scoreboard and bypass behaviour.

## Test plan
- Reset mid-VALID: accept rs1=3 with in_wen=1 and rd=7, then reset_n=1 for one cycle while out_valid=1. Required: next cycle out_valid=0, busy_mask=0, in_ready=1.
- Plain read: with reg5=12 and reg10=14 preloaded, accept rs1=5, rs2=10. Required: two cycles later out_op1=12, out_op2=14, out_valid=1, held until out_ready=1.
- RAW stall: accept rd=2 with wen and complete it, then present rs1=2. Required: in_ready=0. Then wb_valid, wb_addr=2, wb_data=0xAA55AA55AA55AA55. Required: accepted that edge, out_op1=0xAA55AA55AA55AA55, busy_mask[2]=0.
- Same-cycle bypass: register 4 not busy and holds 1. Accept rs2=4 while wb writes 0x1234567890ABCDEF to 4. Required: out_op2=0x1234567890ABCDEF.
- Set/clear collision: accept in_rd=9 with wen in the same cycle as wb_addr=9. Required: busy_mask[9]=1 afterwards.
- Backpressure: hold out_ready=0 for 5 cycles in VALID. Required: outputs stable, in_ready=0. With OPFETCH_ZERO_REG_EN, rs1=0 yields out_op1=0.
